obc_slice_accumulator: RTL and testbench
========================================

// Module: obc_slice_accumulator
// PURPOSE
//  Bit-serial reader for one OBC DFT bin ROM. Latches 16 B-bit two's-complement samples, drives one bit
//  slice (x0..x15) per cycle MSB-first to the combinational bin ROM, and sums the ROM's 8 partial words.
//  It shift-accumulates the slice sums, adds the bin's OBC offset and returns one DFT output component.
//  One instance per ROM (real or imaginary part of one bin) in the 16-point DFT datapath.
// PARAMETERS
//  B      8         sample width in bits (>=2); number of slice cycles
//  RW     32        ROM word width (two's complement, fixed point as stored in ROM)
//  ACC_W  RW+B+3    accumulator/result width (+3 for sum of 8 words, +B for shifts)
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous active-low reset
//  start     in   1        request; accepted only when ready=1
//  samples   in   16*B     sample k at [k*B +: B], two's complement; sampled on accepting edge
//  offset    in   ACC_W    OBC constant term, sign-extended; sampled on accepting edge
//  rom_in0..rom_in7 in RW  ROM partial words for current slice (combinational return, same cycle)
//  x0..x15   out  1        current slice bits to ROM: xk = bit bit_idx of sample k
//  ready     out  1        1 in IDLE and DONE
//  busy      out  1        1 in CALC and OFFS
//  done      out  1        one-cycle pulse, result valid
//  result    out  ACC_W    final value; held until next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, acc=0, result=0, done=0, bit_idx=B-1, sample reg=0 -> x0..x15=0.
//  States: IDLE -start-> CALC; CALC (B cycles, bit_idx B-1 down to 0) -> OFFS (1 cycle) -> DONE -> IDLE.
//  Accepting edge (ready & start): latch samples and offset, bit_idx=B-1, acc=0, enter CALC.
//  x0..x15 are driven from the latched sample register only; they never follow the samples port directly.
//  partial = sum of rom_in0..7, each sign-extended to ACC_W; full precision, no wrap within ACC_W.
//  CALC, bit_idx=B-1: acc <= -partial. CALC, bit_idx<B-1: acc <= (acc<<<1) + partial.
//  bit_idx decrements each CALC cycle; at bit_idx=0 next state OFFS.
//  OFFS: result <= acc + offset (two's complement, wraps at ACC_W); done <= 1 on same edge; next DONE.
//  DONE: done=1 for exactly this cycle; ready=1; start here is accepted (back-to-back, done drops).
//  Latency: done high B+1 edges after the accepting edge. Throughput: one result per B+2 cycles.
//  Back-to-back uses the DONE-state accept path.
//  start while busy: ignored, no effect on state, samples or result.
//  rst_n low mid-operation: abort immediately to reset values; no done pulse for the aborted job.
//  ready and busy are never both 1. Neither is 1 during reset.
//  Outputs are registered except x0..x15, which are direct decode of sample reg and bit_idx.
// TESTING (bench uses stub ROM and B=8 unless noted)
//  Stub: all rom_in=1, samples=0, offset=0 -> partial=8 each slice; result=-8, done on edge 9 after start.
//  Stub: rom_in0 = x0, others 0; sample0=8'h05 -> result=5; sample0=8'hFB -> result=-5; sample0=8'h80 -> -128.
//  Same stub, sample0=8'h05, offset=100 -> result=105; result held through 20 idle cycles.
//  start pulsed at cycles 3 and 5 after accept (busy) -> ignored, exactly one done, result unchanged.
//  Back-to-back: start held high -> second job accepted in DONE cycle, done pulses every 10 cycles.
//  rst_n asserted at CALC bit_idx=4 -> outputs at reset values asynchronously, no done. New job completes correctly.
//  Real bin ROM: 16 random samples -> result matches a golden OBC DFT model bit-exactly.

Source files
------------

// File: rtl/obc_slice_accumulator_if.sv
// Handshake/bus bundle for obc_slice_accumulator.
//   start, samples, offset      : job request and operands (master -> slave)
//   rom_in0..rom_in7            : combinational bin-ROM partial words (master -> slave)
//   x0..x15                     : current bit slice to the ROM address (slave -> master)
//   ready, busy, done, result   : status and registered result (slave -> master)
interface obc_slice_accumulator_if #(
  parameter int B     = 8,
  parameter int RW    = 32,
  parameter int ACC_W = RW + B + 3
);
  logic              start;
  logic [16*B-1:0]   samples;
  logic [ACC_W-1:0]  offset;
  logic [RW-1:0]     rom_in0, rom_in1, rom_in2, rom_in3;
  logic [RW-1:0]     rom_in4, rom_in5, rom_in6, rom_in7;
  logic              x0, x1, x2, x3, x4, x5, x6, x7;
  logic              x8, x9, x10, x11, x12, x13, x14, x15;
  logic              ready;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;

  modport slave (
    input  start, samples, offset,
    input  rom_in0, rom_in1, rom_in2, rom_in3, rom_in4, rom_in5, rom_in6, rom_in7,
    output x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12, x13, x14, x15,
    output ready, busy, done, result
  );

  modport master (
    output start, samples, offset,
    output rom_in0, rom_in1, rom_in2, rom_in3, rom_in4, rom_in5, rom_in6, rom_in7,
    input  x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12, x13, x14, x15,
    input  ready, busy, done, result
  );
endinterface

// File: rtl/obc_slice_accumulator.sv
// Bit-serial reader for one OBC DFT bin ROM.
// Latches 16 B-bit two's-complement samples, presents one bit slice per cycle
// (MSB first) on x0..x15, sums the ROM's 8 partial words, shift-accumulates
// the slice sums (MSB slice weighted negative), adds the OBC offset and
// returns one DFT output component.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : obc_slice_accumulator_if.slave (start/samples/offset/rom_in* in,
//            x0..x15/ready/busy/done/result out)
module obc_slice_accumulator #(
  parameter int B     = 8,
  parameter int RW    = 32,
  parameter int ACC_W = RW + B + 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  obc_slice_accumulator_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OFFS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int            IW      = $clog2(B);
  localparam logic [IW-1:0] IDX_TOP = IW'(B - 1);

  logic [1:0]        state_q,  state_d;
  logic [16*B-1:0]   samp_q,   samp_d;
  logic [ACC_W-1:0]  off_q,    off_d;
  logic [IW-1:0]     idx_q,    idx_d;
  logic [ACC_W-1:0]  acc_q,    acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              done_q,   done_d;
  logic              ready_q,  ready_d;
  logic              busy_q,   busy_d;

  logic [RW-1:0]     rom_w [8];
  logic [ACC_W-1:0]  partial;
  logic [15:0]       slice;
  logic              accept;

  assign rom_w[0] = bus.rom_in0;
  assign rom_w[1] = bus.rom_in1;
  assign rom_w[2] = bus.rom_in2;
  assign rom_w[3] = bus.rom_in3;
  assign rom_w[4] = bus.rom_in4;
  assign rom_w[5] = bus.rom_in5;
  assign rom_w[6] = bus.rom_in6;
  assign rom_w[7] = bus.rom_in7;

  // Full-precision sum of the 8 sign-extended partial words.
  always_comb begin
    partial = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      partial = partial + {{(ACC_W-RW){rom_w[j][RW-1]}}, rom_w[j]};
    end
  end

  // Slice decode from the latched sample register only.
  always_comb begin
    slice = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      slice[k] = samp_q[k*B + 32'(idx_q)];
    end
  end

  assign bus.x0  = slice[0];
  assign bus.x1  = slice[1];
  assign bus.x2  = slice[2];
  assign bus.x3  = slice[3];
  assign bus.x4  = slice[4];
  assign bus.x5  = slice[5];
  assign bus.x6  = slice[6];
  assign bus.x7  = slice[7];
  assign bus.x8  = slice[8];
  assign bus.x9  = slice[9];
  assign bus.x10 = slice[10];
  assign bus.x11 = slice[11];
  assign bus.x12 = slice[12];
  assign bus.x13 = slice[13];
  assign bus.x14 = slice[14];
  assign bus.x15 = slice[15];

  // ready_q is a registered copy of "next state is IDLE/DONE", so it is 0
  // while reset is held and rises on the first edge after release.
  assign accept = ready_q & bus.start;

  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    off_d    = off_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_CALC;
          samp_d  = bus.samples;
          off_d   = bus.offset;
          idx_d   = IDX_TOP;
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        // MSB slice carries negative weight in two's complement.
        if (idx_q == IDX_TOP) begin
          acc_d = '0 - partial;
        end else begin
          acc_d = (acc_q << 1) + partial;
        end
        if (idx_q == '0) begin
          state_d = S_OFFS;
          idx_d   = IDX_TOP;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_OFFS: begin
        result_d = acc_q + off_q;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d  = (state_d == S_CALC) || (state_d == S_OFFS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      samp_q   <= '0;
      off_q    <= '0;
      idx_q    <= IDX_TOP;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      off_q    <= off_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_obc_slice_accumulator.sv
module tb_obc_slice_accumulator;
  localparam int B     = 8;
  localparam int RW    = 32;
  localparam int ACC_W = RW + B + 3;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned cyc = 0;
  int mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obc_slice_accumulator_if #(.B(B), .RW(RW), .ACC_W(ACC_W)) bus ();

  obc_slice_accumulator #(.B(B), .RW(RW), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] xv;
  assign xv = {bus.x15, bus.x14, bus.x13, bus.x12, bus.x11, bus.x10, bus.x9, bus.x8,
               bus.x7,  bus.x6,  bus.x5,  bus.x4,  bus.x3,  bus.x2,  bus.x1, bus.x0};

  // cos(2*pi*k/16) scaled by 2^14: coefficients of a real-part bin-1 ROM.
  function automatic int coef(input int k);
    case (k % 8)
      0: coef = 16384;  1: coef = 15137;  2: coef = 11585;  3: coef = 6270;
      4: coef = 0;      5: coef = -6270;  6: coef = -11585; default: coef = -15137;
    endcase
    if (k >= 8) coef = -coef;
  endfunction

  // Stub ROMs: 0 = all words 1, 1 = rom_in0 follows x0, 2 = pairwise bin ROM.
  logic [RW-1:0] rom [8];
  always_comb begin
    for (int j = 0; j < 8; j++) rom[j] = '0;
    case (mode)
      0: for (int j = 0; j < 8; j++) rom[j] = 32'd1;
      1: rom[0] = {31'd0, xv[0]};
      default:
        for (int j = 0; j < 8; j++)
          rom[j] = RW'((xv[2*j] ? coef(2*j) : 0) + (xv[2*j+1] ? coef(2*j+1) : 0));
    endcase
  end
  assign bus.rom_in0 = rom[0];
  assign bus.rom_in1 = rom[1];
  assign bus.rom_in2 = rom[2];
  assign bus.rom_in3 = rom[3];
  assign bus.rom_in4 = rom[4];
  assign bus.rom_in5 = rom[5];
  assign bus.rom_in6 = rom[6];
  assign bus.rom_in7 = rom[7];

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  typedef struct {
    logic [ACC_W-1:0] res;
    int unsigned      cyc;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [ACC_W-1:0] sx(input longint v);
    sx = v[ACC_W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_busy_excl", {63'd0, bus.ready & bus.busy}, 64'd0);
      if (bus.done) begin
        n_done++;
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending job (cyc=%0d)", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("result", 64'(bus.result), 64'(e.res));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [16*B-1:0] s, input logic [ACC_W-1:0] off,
                       input logic [ACC_W-1:0] e);
    for (int i = 0; i < 50 && !bus.ready; i++) @(negedge clk);
    check("ready_before_issue", {63'd0, bus.ready}, 64'd1);
    bus.samples = s;
    bus.offset  = off;
    bus.start   = 1'b1;
    sbq.push_back('{res: e, cyc: cyc + B + 2});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [16*B-1:0] s0_only(input logic [B-1:0] v);
    logic [16*B-1:0] s;
    s = '0;
    s[B-1:0] = v;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*B-1:0] s;
    longint golden;
    int snap;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.samples = '0;
    bus.offset  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  {63'd0, bus.ready}, 64'd0);
    check("rst_busy",   {63'd0, bus.busy},  64'd0);
    check("rst_done",   {63'd0, bus.done},  64'd0);
    check("rst_result", 64'(bus.result),    64'd0);
    check("rst_x",      64'(xv),            64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, bus.ready}, 64'd1);

    // All ROM words 1: partial 8 per slice -> -8*128 + 8*127 = -8.
    mode = 0;
    issue('0, '0, sx(-8));
    drain();

    // rom_in0 = x0: result is sample0 as a signed number.
    mode = 1;
    issue(s0_only(8'h05), '0, sx(5));
    drain();
    issue(s0_only(8'hFB), '0, sx(-5));
    drain();
    issue(s0_only(8'h80), '0, sx(-128));
    drain();

    // Offset added, result held while idle.
    issue(s0_only(8'h05), sx(100), sx(105));
    drain();
    repeat (20) @(negedge clk);
    check("result_held", 64'(bus.result), 64'(sx(105)));
    check("done_low_idle", {63'd0, bus.done}, 64'd0);

    // start pulsed while busy at cycles 3 and 5 after accept: ignored.
    snap = n_done;
    issue(s0_only(8'h05), '0, sx(5));
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.samples = s0_only(8'h7F); bus.offset = sx(999);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    check("one_done_only", 64'(n_done - snap), 64'd1);
    check("result_after_ignored", 64'(bus.result), 64'(sx(5)));

    // Back-to-back: start held high, second job taken in the DONE cycle.
    for (int i = 0; i < 50 && !bus.ready; i++) @(negedge clk);
    bus.samples = s0_only(8'h05);
    bus.offset  = '0;
    bus.start   = 1'b1;
    sbq.push_back('{res: sx(5),  cyc: cyc + B + 2});
    sbq.push_back('{res: sx(-5), cyc: cyc + 2*B + 4});
    @(negedge clk);
    bus.samples = s0_only(8'hFB);
    repeat (B + 2) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset mid-CALC at bit_idx=4: x must come from the latched samples.
    snap = n_done;
    issue({16{8'hFF}}, '0, sx(0));
    bus.samples = '0;
    repeat (3) @(negedge clk);
    check("x_from_latch", 64'(xv), 64'hFFFF);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ready",  {63'd0, bus.ready}, 64'd0);
    check("abort_busy",   {63'd0, bus.busy},  64'd0);
    check("abort_done",   {63'd0, bus.done},  64'd0);
    check("abort_result", 64'(bus.result),    64'd0);
    check("abort_x",      64'(xv),            64'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("no_done_after_abort", 64'(n_done - snap), 64'd0);
    issue(s0_only(8'h05), sx(3), sx(8));
    drain();

    // Bin ROM against a direct DFT dot product.
    mode = 2;
    for (int t = 0; t < 3; t++) begin
      golden = (t == 2) ? -64'sd1000 : 64'sd0;
      for (int k = 0; k < 16; k++) begin
        logic [B-1:0] v;
        v = B'($urandom);
        s[k*B +: B] = v;
        golden += longint'(coef(k)) * longint'($signed(v));
      end
      issue(s, (t == 2) ? sx(-1000) : '0, sx(golden));
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
